ring_osc_meter: RTL and testbench
=================================

RING_OSC_METER -- requirements
Module: ring_osc_meter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of ring-oscillator inputs (>=1).
REQ-002 SHALL have parameter COUNT_WIDTH, default 16: edge-counter width.
REQ-003 SHALL have parameter GATE_WIDTH, default 8: width of gate_len.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 4: ring warm-up cycles before counting (>=1).
REQ-005 SHALL define local CH_W = max(1, clog2(NUM_CHANNELS)).
REQ-006 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: start  in  1  measurement request, sampled on every clk rising edge.
REQ-008 SHALL have ports: chan_sel  in  CH_W  channel to measure; gate_len  in  GATE_WIDTH  count window in clk cycles.
REQ-009 SHALL have ports: osc_in  in  NUM_CHANNELS  asynchronous ring-oscillator taps; osc_en  out  NUM_CHANNELS  ring enables.
REQ-010 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; err  out  1; count  out  COUNT_WIDTH; overflow  out  1.

Function
REQ-011 SHALL implement states IDLE, SETTLE, GATE, DONE; busy = 1 in SETTLE and GATE only.
REQ-012 In IDLE, start=1 with chan_sel < NUM_CHANNELS and gate_len != 0 SHALL be accepted: latch chan_sel and gate_len, clear count, overflow and err, and enter SETTLE.
REQ-013 In IDLE, start=1 with chan_sel >= NUM_CHANNELS or gate_len == 0 SHALL enter DONE with err=1 and count=0; osc_en SHALL stay 0.
REQ-014 start SHALL be ignored in SETTLE, GATE and DONE; chan_sel and gate_len SHALL be ignored except at acceptance.
REQ-015 osc_en SHALL be one-hot on the latched channel in SETTLE and GATE, and all-zero otherwise.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles; GATE SHALL last exactly the latched gate_len cycles.
REQ-017 Edge detection path: osc_in[latched channel] -> 2-flop synchroniser -> third flop; edge = sync2 & ~sync3.
REQ-018 The synchroniser and edge flops SHALL run in every state; edges SHALL be counted only in GATE cycles.
REQ-019 count SHALL increment by 1 per edge and saturate at 2^COUNT_WIDTH-1; an edge at saturation SHALL set overflow, which stays set until the next acceptance.
REQ-020 Timing for start accepted at edge T: busy is 1 from T+1 through T+SETTLE_CYCLES+gate_len; done=1 for exactly the single cycle after that.
REQ-021 For the err path, done SHALL be 1 for exactly cycle T+1.
REQ-022 DONE SHALL always return to IDLE after one cycle.
REQ-023 count, overflow and err SHALL hold their values from DONE until the next acceptance.
REQ-024 A start that is high in the DONE cycle SHALL be ignored; the earliest next acceptance is the following IDLE cycle.

Reset
REQ-025 rst=1 at a clk edge SHALL force IDLE, osc_en=0, busy=0, done=0, err=0, count=0, overflow=0, and clear all synchroniser flops.
REQ-026 rst SHALL take priority over start, including a start in the same cycle.
REQ-027 rst asserted mid-SETTLE or mid-GATE SHALL abort the measurement without a done pulse.

Verification
REQ-028 Defaults, chan_sel=1, gate_len=32, osc_in[1] square wave of period 4 clk driven synchronously -> osc_en=4'b0010 while busy; done at T+37; count=8; overflow=0; err=0.
REQ-029 COUNT_WIDTH=4, osc_in[0] period 2 clk, gate_len=64 -> count=15, overflow=1.
REQ-030 NUM_CHANNELS=3, chan_sel=3, start -> done at T+1, err=1, count=0; osc_en=0 throughout. Repeat with gate_len=0 -> same response.
REQ-031 osc_in[2] toggling, osc_in[0] static, chan_sel=0, gate_len=20 -> count=0; start pulses during busy -> no restart and the done timing is unchanged.
REQ-032 rst pulsed at GATE cycle 10 -> next cycle IDLE, osc_en=0, count=0, no done pulse; a new start two cycles later is accepted normally.

Source files
------------

// File: rtl/ring_osc_meter.sv
// Ring-oscillator frequency meter: warms up one selected ring for a
// fixed settle time, then counts its synchronised rising edges over a
// programmable gate window and reports a saturating count.
//
// Ports:
//   clk, rst             sole clock, synchronous active-high reset
//   start                measurement request (sampled every rising edge)
//   chan_sel, gate_len   channel and gate length, latched at acceptance
//   osc_in               asynchronous ring-oscillator taps
//   osc_en               one-hot ring enable while measuring
//   busy, done, err      status; done is a one-cycle pulse
//   count, overflow      saturating edge count and saturation flag
module ring_osc_meter #(
    parameter int NUM_CHANNELS  = 4,
    parameter int COUNT_WIDTH   = 16,
    parameter int GATE_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 4,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CH_W-1:0]         chan_sel,
    input  logic [GATE_WIDTH-1:0]   gate_len,
    input  logic [NUM_CHANNELS-1:0] osc_in,
    output logic [NUM_CHANNELS-1:0] osc_en,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [COUNT_WIDTH-1:0]  count,
    output logic                    overflow
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = (GATE_WIDTH > SW) ? GATE_WIDTH : SW;
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [31:0] NCH = NUM_CHANNELS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [CH_W-1:0]         ch_q;
    logic [GATE_WIDTH-1:0]   gate_q;
    logic [TW-1:0]           timer_q;
    logic [NUM_CHANNELS-1:0] osc_en_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic                    ovf_q;

    logic sync1_q, sync2_q, sync3_q;
    logic edge_w;
    logic chan_ok;
    logic [NUM_CHANNELS-1:0] sel_onehot;

    assign chan_ok    = ({{(32-CH_W){1'b0}}, chan_sel} < NCH);
    assign sel_onehot = NUM_CHANNELS'(1) << chan_sel;
    assign edge_w     = sync2_q & ~sync3_q;

    // The synchroniser follows the latched channel in every state so the
    // chain is already primed with the new ring by the time GATE opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= osc_in[ch_q];
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            gate_q   <= '0;
            timer_q  <= '0;
            osc_en_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        if (chan_ok && (gate_len != '0)) begin
                            ch_q     <= chan_sel;
                            gate_q   <= gate_len;
                            timer_q  <= SETTLE_LAST;
                            osc_en_q <= sel_onehot;
                            busy_q   <= 1'b1;
                            err_q    <= 1'b0;
                            state_q  <= S_SETTLE;
                        end else begin
                            // Rejected request: report straight away.
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (timer_q == '0) begin
                        timer_q <= TW'(gate_q) - TW'(1);
                        state_q <= S_GATE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_GATE: begin
                    if (edge_w) begin
                        if (count_q == CNT_MAX) begin
                            ovf_q <= 1'b1;
                        end else begin
                            count_q <= count_q + COUNT_WIDTH'(1);
                        end
                    end
                    if (timer_q == '0) begin
                        osc_en_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign osc_en   = osc_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Testbench for ring_osc_meter: two instances (default and a 3-channel,
// 4-bit-count variant) share stimulus and are checked cycle by cycle.
module tb_ring_osc_meter;

    localparam int S = 4;
    localparam int NCH [2] = '{4, 3};
    localparam int CW  [2] = '{16, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [1:0] chan_sel;
    logic [7:0] gate_len;
    logic [3:0] osc_in;

    logic [3:0]  a_en;
    logic        a_busy, a_done, a_err, a_ovf;
    logic [15:0] a_cnt;
    logic [2:0]  b_en;
    logic        b_busy, b_done, b_err, b_ovf;
    logic [3:0]  b_cnt;

    ring_osc_meter u_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .chan_sel (chan_sel),
        .gate_len (gate_len),
        .osc_in   (osc_in),
        .osc_en   (a_en),
        .busy     (a_busy),
        .done     (a_done),
        .err      (a_err),
        .count    (a_cnt),
        .overflow (a_ovf)
    );

    ring_osc_meter #(
        .NUM_CHANNELS (3),
        .COUNT_WIDTH  (4)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .chan_sel (chan_sel),
        .gate_len (gate_len),
        .osc_in   (osc_in[2:0]),
        .osc_en   (b_en),
        .busy     (b_busy),
        .done     (b_done),
        .err      (b_err),
        .count    (b_cnt),
        .overflow (b_ovf)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int mode  = 0;
    logic [3:0] hist [0:16383];

    // Reference model: each measurement is described by its acceptance
    // cycle and its done cycle; everything else follows by arithmetic.
    int  t_acc [2];
    int  t_end [2];
    bit  m_valid [2];
    bit  m_err [2];
    bit  m_ovf [2];
    int  m_ch [2];
    int  m_g [2];
    int  m_cnt [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit idle(int d);
        return cyc > t_end[d];
    endfunction

    function automatic bit in_meas(int d);
        return m_valid[d] && cyc >= t_acc[d] && cyc < t_end[d];
    endfunction

    // Rising edges of the selected ring seen through a 2-flop synchroniser
    // plus edge flop, over the gate window, saturated to the counter size.
    task automatic finish_meas(int d);
        int e;
        int mx;
        e = 0;
        for (int m = t_acc[d] + S; m < t_acc[d] + S + m_g[d]; m++)
            if (hist[m-2][m_ch[d]] && !hist[m-3][m_ch[d]]) e++;
        mx = (1 << CW[d]) - 1;
        m_cnt[d] = (e > mx) ? mx : e;
        m_ovf[d] = (e > mx);
    endtask

    task automatic model_edge(int d);
        if (rst) begin
            t_end[d]   = cyc - 1;
            m_valid[d] = 1'b0;
            m_err[d]   = 1'b0;
            m_ovf[d]   = 1'b0;
            m_cnt[d]   = 0;
        end else if (start && (cyc - 1 > t_end[d])) begin
            t_acc[d] = cyc;
            m_cnt[d] = 0;
            m_ovf[d] = 1'b0;
            if (int'(chan_sel) < NCH[d] && gate_len != 0) begin
                m_valid[d] = 1'b1;
                m_err[d]   = 1'b0;
                m_ch[d]    = int'(chan_sel);
                m_g[d]     = int'(gate_len);
                t_end[d]   = cyc + S + m_g[d];
            end else begin
                m_valid[d] = 1'b0;
                m_err[d]   = 1'b1;
                t_end[d]   = cyc;
            end
        end
        if (m_valid[d] && cyc == t_end[d]) finish_meas(d);
    endtask

    task automatic check_dut(int d);
        logic [3:0] e_en;
        bit         meas;
        bit         cnt_stable;
        logic [3:0] o_en;
        logic       o_busy, o_done, o_err, o_ovf;
        logic [15:0] o_cnt;
        meas = in_meas(d);
        e_en = meas ? 4'(1 << m_ch[d]) : 4'b0;
        cnt_stable = !meas || (cyc < t_acc[d] + S);
        if (d == 0) begin
            o_en = a_en; o_busy = a_busy; o_done = a_done;
            o_err = a_err; o_ovf = a_ovf; o_cnt = a_cnt;
        end else begin
            o_en = {1'b0, b_en}; o_busy = b_busy; o_done = b_done;
            o_err = b_err; o_ovf = b_ovf; o_cnt = {12'b0, b_cnt};
        end
        chk($sformatf("busy%0d@%0d", d, cyc), 32'(o_busy), 32'(meas));
        chk($sformatf("done%0d@%0d", d, cyc), 32'(o_done),
            32'(cyc == t_end[d]));
        chk($sformatf("osc_en%0d@%0d", d, cyc), 32'(o_en), 32'(e_en));
        chk($sformatf("err%0d@%0d", d, cyc), 32'(o_err), 32'(m_err[d]));
        if (cnt_stable) begin
            chk($sformatf("count%0d@%0d", d, cyc), 32'(o_cnt), m_cnt[d]);
            chk($sformatf("ovf%0d@%0d", d, cyc), 32'(o_ovf),
                32'(m_ovf[d]));
        end
    endtask

    function automatic logic [3:0] gen_osc();
        logic [31:0] c;
        logic        r;
        c = cyc;
        r = 1'($urandom);
        unique case (mode)
            1:       return {r, ~c[0], c[1], c[0]};
            2:       return {r, c[0], c[1], 1'b0};
            default: return 4'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        check_dut(0);
        check_dut(1);
        osc_in = gen_osc();
        hist[cyc] = osc_in;
    endtask

    task automatic wait_idle(bit pulse);
        int i;
        i = 0;
        while (!(idle(0) && idle(1)) && i < 600) begin
            if (pulse && in_meas(0) && in_meas(1)) begin
                start    = 1'($urandom);
                chan_sel = 2'($urandom);
                gate_len = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            i++;
        end
        start = 1'b0;
        chk("idle_timeout", 32'(idle(0) && idle(1)), 32'd1);
    endtask

    task automatic run(int sel, int gl, bit pulse);
        start    = 1'b1;
        chan_sel = 2'(sel);
        gate_len = 8'(gl);
        tick();
        start = 1'b0;
        wait_idle(pulse);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            t_acc[d] = -100; t_end[d] = -100;
            m_valid[d] = 0; m_err[d] = 0; m_ovf[d] = 0;
            m_ch[d] = 0; m_g[d] = 0; m_cnt[d] = 0;
        end
        rst = 1'b1; start = 1'b1; chan_sel = 2'd1; gate_len = 8'd8;
        osc_in = 4'b0; hist[0] = 4'b0;
        repeat (3) tick();
        rst = 1'b0; start = 1'b0;
        tick();
        chk("reset_busy", 32'(a_busy), 32'd0);
        chk("reset_osc_en", 32'(a_en), 32'd0);

        // Square waves: ch1 period 4, ch0 period 2.
        mode = 1;
        run(1, 32, 1'b0);
        chk("sq_p4_count", 32'(a_cnt), 32'd8);
        chk("sq_p4_ovf", 32'(a_ovf), 32'd0);
        run(0, 64, 1'b0);
        chk("sat_count", 32'(b_cnt), 32'd15);
        chk("sat_ovf", 32'(b_ovf), 32'd1);
        chk("wide_count", 32'(a_cnt), 32'd32);

        // Invalid channel on the 3-channel unit, then zero gate on both.
        run(3, 10, 1'b0);
        chk("badch_err", 32'(b_err), 32'd1);
        chk("badch_cnt", 32'(b_cnt), 32'd0);
        chk("badch_ok_a", 32'(a_err), 32'd0);
        run(1, 0, 1'b0);
        chk("gate0_err", 32'(a_err), 32'd1);

        // Static selected ring, stray start pulses while busy.
        mode = 2;
        run(0, 20, 1'b1);
        chk("static_count", 32'(a_cnt), 32'd0);

        // start held through the DONE cycle is only taken afterwards.
        start = 1'b1; chan_sel = 2'd1; gate_len = 8'd5;
        tick();
        start = 1'b0;
        while (cyc < t_end[0]) tick();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(a_busy), 32'd1);
        wait_idle(1'b0);

        // Reset in the tenth gate cycle, with start held alongside.
        mode = 1;
        start = 1'b1; chan_sel = 2'd1; gate_len = 8'd32;
        tick();
        start = 1'b0;
        while (cyc < t_acc[0] + S + 9) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_count", 32'(a_cnt), 32'd0);
        tick();
        tick();
        run(1, 12, 1'b0);
        chk("after_abort", 32'(a_cnt), 32'd3);

        // Randomised measurements.
        for (int k = 0; k < 30; k++) begin
            mode = int'($urandom_range(0, 2));
            run(int'($urandom_range(0, 3)),
                (k % 7 == 3) ? 0 : int'($urandom_range(1, 40)),
                1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
